// File: rtl/onehot_sequencer_if.sv
// rtl/onehot_sequencer_if.sv - control and one-hot select bundle for onehot_sequencer
interface onehot_sequencer_if #(
    parameter int SEL_W = 3
);
    localparam int OUT_W = 1 << SEL_W;

    logic             en;
    logic [1:0]       mode;
    logic             load;
    logic [SEL_W-1:0] sel;
    logic [OUT_W-1:0] out;
    logic [SEL_W-1:0] idx;
    logic             active;
    logic             tc;

    modport master (output en, mode, load, sel, input out, idx, active, tc);
    modport slave  (input en, mode, load, sel, output out, idx, active, tc);
endinterface

// File: rtl/onehot_sequencer.sv
// rtl/onehot_sequencer.sv - registered binary-to-one-hot decoder with up/down sequencing
module onehot_sequencer #(
    parameter int SEL_W = 3,
    parameter bit WRAP  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    onehot_sequencer_if.slave bus
);
    localparam int OUT_W = 1 << SEL_W;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_DOWN   = 2'b10;

    localparam logic [SEL_W-1:0] IDX_MAX = '1;

    logic [SEL_W-1:0] idx_r, idx_nxt;
    logic             active_r, active_nxt;
    logic             tc_r, tc_nxt;
    logic [OUT_W-1:0] out_r, out_nxt;

    always_comb begin
        idx_nxt    = idx_r;
        active_nxt = active_r;
        tc_nxt     = 1'b0;
        if (!bus.en) begin
            active_nxt = 1'b0;
        end else if (bus.load || bus.mode == MODE_DIRECT) begin
            idx_nxt    = bus.sel;
            active_nxt = 1'b1;
        end else if (bus.mode == MODE_UP || bus.mode == MODE_DOWN) begin
            // The first enabled cycle only re-asserts the output at the retained index.
            if (!active_r) begin
                active_nxt = 1'b1;
            end else if (bus.mode == MODE_UP) begin
                if (idx_r != IDX_MAX) begin
                    idx_nxt = idx_r + 1'b1;
                    tc_nxt  = !WRAP && (idx_nxt == IDX_MAX);
                end else if (WRAP) begin
                    idx_nxt = '0;
                    tc_nxt  = 1'b1;
                end
            end else begin
                if (idx_r != '0) begin
                    idx_nxt = idx_r - 1'b1;
                    tc_nxt  = !WRAP && (idx_nxt == '0);
                end else if (WRAP) begin
                    idx_nxt = IDX_MAX;
                    tc_nxt  = 1'b1;
                end
            end
        end
    end

    // Decoding from next state keeps the one-hot output a direct flop, free of decode glitches.
    always_comb begin
        out_nxt = '0;
        if (active_nxt) begin
            out_nxt = OUT_W'(1) << idx_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r    <= '0;
            active_r <= 1'b0;
            tc_r     <= 1'b0;
            out_r    <= '0;
        end else begin
            idx_r    <= idx_nxt;
            active_r <= active_nxt;
            tc_r     <= tc_nxt;
            out_r    <= out_nxt;
        end
    end

    assign bus.out    = out_r;
    assign bus.idx    = idx_r;
    assign bus.active = active_r;
    assign bus.tc     = tc_r;
endmodule

// File: tb/tb_onehot_sequencer.sv
// tb/tb_onehot_sequencer.sv - randomized and directed bench for onehot_sequencer, wrap and saturate
module tb_onehot_sequencer;
    localparam int N = 8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       load;
    logic [1:0] mode;
    logic [2:0] sel;

    int nchk = 0;
    int nerr = 0;

    onehot_sequencer_if #(.SEL_W(3)) ifa ();
    onehot_sequencer_if #(.SEL_W(3)) ifb ();

    assign ifa.en = en;
    assign ifa.mode = mode;
    assign ifa.load = load;
    assign ifa.sel = sel;
    assign ifb.en = en;
    assign ifb.mode = mode;
    assign ifb.load = load;
    assign ifb.sel = sel;

    onehot_sequencer #(.SEL_W(3), .WRAP(1'b1)) dut_wrap (.clk(clk), .rst_n(rst_n), .bus(ifa));
    onehot_sequencer #(.SEL_W(3), .WRAP(1'b0)) dut_sat  (.clk(clk), .rst_n(rst_n), .bus(ifb));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model index 0 wraps, index 1 saturates.
    int m_idx[2];
    bit m_act[2];
    bit m_tc[2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < 2; w++) begin
                m_idx[w] <= 0;
                m_act[w] <= 1'b0;
                m_tc[w]  <= 1'b0;
            end
        end else begin
            for (int w = 0; w < 2; w++) begin
                int p;
                bit a;
                bit t;
                p = m_idx[w];
                a = m_act[w];
                t = 1'b0;
                if (!en) begin
                    a = 1'b0;
                end else if (load || mode == 2'd0) begin
                    p = int'(sel);
                    a = 1'b1;
                end else if (mode == 2'd1 || mode == 2'd2) begin
                    if (!a) begin
                        a = 1'b1;
                    end else if (mode == 2'd1) begin
                        if (p < N - 1) begin
                            p = p + 1;
                            t = (w == 1) && (p == N - 1);
                        end else if (w == 0) begin
                            p = 0;
                            t = 1'b1;
                        end
                    end else begin
                        if (p > 0) begin
                            p = p - 1;
                            t = (w == 1) && (p == 0);
                        end else if (w == 0) begin
                            p = N - 1;
                            t = 1'b1;
                        end
                    end
                end
                m_idx[w] <= p;
                m_act[w] <= a;
                m_tc[w]  <= t;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [7:0] d_out[2];
    logic [2:0] d_idx[2];
    logic       d_act[2];
    logic       d_tc[2];
    assign d_out[0] = ifa.out;
    assign d_out[1] = ifb.out;
    assign d_idx[0] = ifa.idx;
    assign d_idx[1] = ifb.idx;
    assign d_act[0] = ifa.active;
    assign d_act[1] = ifb.active;
    assign d_tc[0]  = ifa.tc;
    assign d_tc[1]  = ifb.tc;

    always @(negedge clk) begin
        for (int w = 0; w < 2; w++) begin
            logic [7:0] e_out;
            e_out = m_act[w] ? (8'd1 << m_idx[w]) : 8'd0;
            chk(w == 0 ? "model_out_wrap" : "model_out_sat", 32'(d_out[w]), 32'(e_out));
            chk(w == 0 ? "model_idx_wrap" : "model_idx_sat", 32'(d_idx[w]), 32'(m_idx[w]));
            chk(w == 0 ? "model_act_wrap" : "model_act_sat", 32'(d_act[w]), 32'(m_act[w]));
            chk(w == 0 ? "model_tc_wrap" : "model_tc_sat", 32'(d_tc[w]), 32'(m_tc[w]));
            chk("onehot_or_zero", 32'($countones(d_out[w]) <= 1), 32'd1);
        end
    end

    task automatic cyc(input logic e, input logic [1:0] m, input logic l, input logic [2:0] s);
        en   = e;
        mode = m;
        load = l;
        sel  = s;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_a(input string name, input logic [2:0] i, input logic [7:0] o, input logic t);
        chk({name, "_idx_wrap"}, 32'(ifa.idx), 32'(i));
        chk({name, "_out_wrap"}, 32'(ifa.out), 32'(o));
        chk({name, "_tc_wrap"}, 32'(ifa.tc), 32'(t));
    endtask

    task automatic expect_b(input string name, input logic [2:0] i, input logic [7:0] o, input logic t);
        chk({name, "_idx_sat"}, 32'(ifb.idx), 32'(i));
        chk({name, "_out_sat"}, 32'(ifb.out), 32'(o));
        chk({name, "_tc_sat"}, 32'(ifb.tc), 32'(t));
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 2'd0;
        load  = 1'b0;
        sel   = 3'd0;
        #1;
        expect_a("reset", 3'd0, 8'h00, 1'b0);
        chk("reset_active", 32'(ifa.active), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int s = 0; s < N; s++) begin
            cyc(1'b1, 2'd0, 1'b0, 3'(s));
            chk("direct_out", 32'(ifa.out), 32'h1 << s);
            chk("direct_idx", 32'(ifb.idx), 32'(s));
        end

        cyc(1'b1, 2'd1, 1'b1, 3'd6);
        expect_a("wrap0", 3'd6, 8'h40, 1'b0);
        cyc(1'b1, 2'd1, 1'b0, 3'd0);
        expect_a("wrap1", 3'd7, 8'h80, 1'b0);
        expect_b("wrap1", 3'd7, 8'h80, 1'b1);
        cyc(1'b1, 2'd1, 1'b0, 3'd0);
        expect_a("wrap2", 3'd0, 8'h01, 1'b1);
        expect_b("wrap2", 3'd7, 8'h80, 1'b0);
        cyc(1'b1, 2'd1, 1'b0, 3'd0);
        expect_a("wrap3", 3'd1, 8'h02, 1'b0);

        cyc(1'b1, 2'd2, 1'b1, 3'd2);
        expect_b("sat0", 3'd2, 8'h04, 1'b0);
        cyc(1'b1, 2'd2, 1'b0, 3'd0);
        expect_b("sat1", 3'd1, 8'h02, 1'b0);
        cyc(1'b1, 2'd2, 1'b0, 3'd0);
        expect_b("sat2", 3'd0, 8'h01, 1'b1);
        expect_a("sat2", 3'd0, 8'h01, 1'b0);
        cyc(1'b1, 2'd2, 1'b0, 3'd0);
        expect_b("sat3", 3'd0, 8'h01, 1'b0);
        expect_a("sat3", 3'd7, 8'h80, 1'b1);
        cyc(1'b1, 2'd2, 1'b0, 3'd0);
        expect_b("sat4", 3'd0, 8'h01, 1'b0);

        cyc(1'b1, 2'd1, 1'b1, 3'd3);
        cyc(1'b1, 2'd1, 1'b0, 3'd0);
        expect_a("gap_pre", 3'd4, 8'h10, 1'b0);
        cyc(1'b0, 2'd1, 1'b0, 3'd0);
        expect_a("gap_off1", 3'd4, 8'h00, 1'b0);
        chk("gap_off1_active", 32'(ifa.active), 32'd0);
        cyc(1'b0, 2'd1, 1'b0, 3'd0);
        expect_b("gap_off2", 3'd4, 8'h00, 1'b0);
        cyc(1'b1, 2'd1, 1'b0, 3'd0);
        expect_a("gap_on1", 3'd4, 8'h10, 1'b0);
        cyc(1'b1, 2'd1, 1'b0, 3'd0);
        expect_a("gap_on2", 3'd5, 8'h20, 1'b0);

        cyc(1'b1, 2'd1, 1'b1, 3'd7);
        cyc(1'b1, 2'd1, 1'b1, 3'd5);
        expect_a("prio", 3'd5, 8'h20, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 2'd3, 1'b0, 3'($urandom_range(0, 7)));
            expect_a("hold", 3'd5, 8'h20, 1'b0);
        end

        for (int k = 0; k < 600; k++) begin
            cyc($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)),
                $urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)));
        end

        cyc(1'b1, 2'd1, 1'b1, 3'd3);
        cyc(1'b1, 2'd1, 1'b0, 3'd0);
        #3;
        rst_n = 1'b0;
        #1;
        expect_a("arst", 3'd0, 8'h00, 1'b0);
        expect_b("arst", 3'd0, 8'h00, 1'b0);
        chk("arst_active", 32'(ifa.active), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 2'd1, 1'b0, 3'd0);
        expect_a("post_rst1", 3'd0, 8'h01, 1'b0);
        chk("post_rst1_active", 32'(ifa.active), 32'd1);
        cyc(1'b1, 2'd1, 1'b0, 3'd0);
        expect_a("post_rst2", 3'd1, 8'h02, 1'b0);
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/onehot_sequencer.md
# onehot_sequencer

Parametrised, registered binary-to-one-hot decoder with built-in sequencing. It either decodes a select word every cycle (direct mode) or walks a one-hot pointer up or down across `2**SEL_W` outputs, with load, hold, wrap/saturate and terminal-count indication. It drives one-hot enables for banked resources, such as row/bank selects and time-slot strobes, where a registered, glitch-free select is required.

## Interface
- `SEL_W`, 3: select/index width; output width `OUT_W = 2**SEL_W` (derived, not overridable); legal 1..6.
- `WRAP`, 1: 1 = pointer wraps at the ends in step modes; 0 = pointer saturates at the end and stops.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; deassertion synchronised externally.
- `en`  in  1  block enable; low forces the output to all-zero on the next edge.
- `mode`  in  2  00 direct, 01 step-up, 10 step-down, 11 hold.
- `load`  in  1  load `sel` into the pointer (priority over mode when `en`=1).
- `sel`  in  SEL_W  index for load/direct decode.
- `out`  out  OUT_W  registered one-hot output (or all-zero when inactive).
- `idx`  out  SEL_W  registered current pointer value.
- `active`  out  1  registered; 1 when `out` is one-hot.
- `tc`  out  1  registered one-cycle pulse on a terminal step (wrap, or arrival at the end under saturate).

## Operation
- State: `idx_r` (SEL_W), `active_r`, `tc_r`. `out` = `active_r` ? (1 << `idx_r`) : 0, registered. It is never computed combinationally from inputs.
- Priority per edge, highest first:
  1. `en`=0: `active_r`←0, `tc_r`←0, `idx_r` retained.
  2. `load`=1: `idx_r`←`sel`, `active_r`←1, `tc_r`←0.
  3. mode 00 (direct): `idx_r`←`sel`, `active_r`←1, `tc_r`←0.
  4. mode 01/10 with `active_r`=0: `active_r`←1, `idx_r` unchanged. There is no advance on the first enabled cycle.
  5. mode 01 with `active_r`=1: if `idx_r`<MAX, `idx_r`+1. If `idx_r`=MAX: with WRAP=1, `idx_r`←0 and `tc_r`←1; with WRAP=0, hold at MAX.
  6. mode 10 with `active_r`=1: mirror of step-up, with 0 as the end and MAX as the wrap target.
  7. mode 11 (hold): all state retained, `tc_r`←0.
- MAX = `2**SEL_W`−1. Pointer arithmetic is SEL_W-bit modulo, with no overflow bit.
- Saturate mode (WRAP=0):
  - `tc_r`←1 on the step that lands on the end (MAX for up, 0 for down).
  - Further steps hold at the end with `tc_r`=0. `tc` does not re-fire while parked.
- `tc_r` is 0 on every cycle not explicitly listed above.
- Mode change mid-sequence takes effect on the next edge from the current `idx_r`. There is no restart.
- `load` together with any mode: the load wins, and mode is ignored for that edge.

## Timing
- Reset (asynchronous, immediate): `idx`=0, `active`=0, `out`=0, `tc`=0.
- Reset asserted mid-sequence clears all state within the same cycle, independent of `clk`.
- Latency: input sampled at edge N, so `out`/`idx`/`active`/`tc` reflect it after edge N.
- Direct mode throughput is one new decode per cycle.
- Step modes advance one position per enabled cycle, so a full up-sweep with WRAP=1 has period `OUT_W` cycles.
- `en` low for one cycle, then high in a step mode:
  - Cycle after `en` returns: `out` reasserts at the retained `idx` (rule 4).
  - Following cycle: the first advance.
- `out` is one-hot or zero after every edge. A multi-hot value is a design error.

## Test plan
- Reset/direct: with SEL_W=3, assert `rst_n`=0, then confirm `out`=0, `idx`=0, `active`=0, `tc`=0. Release reset and hold `en`=1, mode=00. Sweep `sel` through 0..7. Each cycle, `out` must equal 1<<`sel` of the previous cycle, covering 8'h01 through 8'h80.
- Step-up wrap: with WRAP=1, `load` `sel`=6, then mode=01 for 4 cycles. Expect `idx` = 6, 7, 0, 1, with `tc`=1 only on the cycle `idx` becomes 0. `out` = 8'h40, 8'h80, 8'h01, 8'h02.
- Step-down saturate: with WRAP=0, `load` `sel`=2, then mode=10 for 5 cycles. Expect `idx` = 2, 1, 0, 0, 0, with `tc`=1 only on arrival at 0 and `out` parked at 8'h01.
- Enable gap: while stepping up at `idx`=4, drop `en` for 2 cycles. Expect `out`=0 and `active`=0 with `idx` holding at 4. Re-enable: `out`=8'h10 on the first cycle, then 8'h20.
- Priority/simultaneous: in mode=01, assert `load` with `sel`=5 on the same cycle the pointer would wrap from 7. Expect `idx`=5 and `tc`=0. Then mode=11 for 3 cycles, with `out` holding at 8'h20.
- Async reset mid-run: while stepping, assert `rst_n` between clock edges. Outputs must go to zero before the next edge. After release with mode=01, the first enabled cycle gives `out`=8'h01 with no advance.
